// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU serial command receiver: opcode and
// packet encodings, error flag layout, CRC4 over the 68-bit command image.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } alu_op_t;

    typedef enum logic {
        PKT_DATA = 1'b0,
        PKT_CTL  = 1'b1
    } packet_t;

    typedef struct packed {
        logic data;
        logic crc;
        logic op;
    } rx_err_t;

    localparam rx_err_t ERR_NONE = rx_err_t'(3'b000);
    localparam rx_err_t ERR_DATA = rx_err_t'(3'b100);
    localparam rx_err_t ERR_CRC  = rx_err_t'(3'b010);
    localparam rx_err_t ERR_OP   = rx_err_t'(3'b001);

    // Serial CRC4, poly x^4+x+1, init 0, d[67] shifted in first.
    function automatic logic [3:0] crc4_d68(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic op_is_valid(input logic [2:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_rx_frame.sv
// Single-packet deserialiser: start, type, 8 data bits MSB first, stop.
// Emits a one-cycle pkt_done with the captured fields after the stop sample.
module alu_rx_frame (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic       pkt_done,
    output logic       pkt_type,
    output logic [7:0] pkt_data,
    output logic       pkt_stop_err,
    output logic       frame_idle,
    output logic       frame_stop
);

    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_TYPE = 2'd1;
    localparam logic [1:0] F_BITS = 2'd2;
    localparam logic [1:0] F_STOP = 2'd3;

    logic [1:0] state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       type_r;
    logic       pkt_done_r;
    logic       pkt_type_r;
    logic [7:0] pkt_data_r;
    logic       pkt_stop_err_r;

    assign frame_idle   = (state_r == F_IDLE);
    assign frame_stop   = (state_r == F_STOP);
    assign pkt_done     = pkt_done_r;
    assign pkt_type     = pkt_type_r;
    assign pkt_data     = pkt_data_r;
    assign pkt_stop_err = pkt_stop_err_r;

    // Bit-level framing FSM and packet capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= F_IDLE;
            bit_cnt_r      <= 3'd0;
            shift_r        <= 8'h00;
            type_r         <= 1'b0;
            pkt_done_r     <= 1'b0;
            pkt_type_r     <= 1'b0;
            pkt_data_r     <= 8'h00;
            pkt_stop_err_r <= 1'b0;
        end else begin
            pkt_done_r <= 1'b0;
            case (state_r)
                F_IDLE: begin
                    if (!sin) begin
                        state_r <= F_TYPE;
                    end else begin
                        state_r <= F_IDLE;
                    end
                end
                F_TYPE: begin
                    type_r    <= sin;
                    bit_cnt_r <= 3'd0;
                    state_r   <= F_BITS;
                end
                F_BITS: begin
                    shift_r <= {shift_r[6:0], sin};
                    if (bit_cnt_r == 3'd7) begin
                        state_r <= F_STOP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                end
                F_STOP: begin
                    pkt_done_r     <= 1'b1;
                    pkt_type_r     <= type_r;
                    pkt_data_r     <= shift_r;
                    pkt_stop_err_r <= ~sin;
                    state_r        <= F_IDLE;
                end
                default: begin
                    state_r <= F_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_serial_rx.sv
// ALU-side command receiver: collects 8 DATA packets and one CTL packet from
// sin, validates framing, CRC4 and opcode, then pulses operands or an error.
module alu_serial_rx
    import alu_pkg::*;
#(
    parameter int N_DATA_PKTS = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        rx_valid,
    output logic [31:0] rx_a,
    output logic [31:0] rx_b,
    output logic [2:0]  rx_op,
    output logic        rx_err_valid,
    output logic [2:0]  rx_err_flags,
    output logic        rx_busy
);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_CHECK   = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;

    localparam logic [3:0] CNT_FULL = 4'(N_DATA_PKTS);
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_ZERO = TO_W'(0);

    logic                       pkt_done_s;
    logic                       pkt_type_s;
    logic [7:0]                 pkt_data_s;
    logic                       pkt_stop_err_s;
    logic                       frame_idle_s;
    logic                       frame_stop_s;

    logic [1:0]                 state_r;
    logic [1:0]                 state_nxt_s;
    logic [3:0]                 cnt_r;
    logic [3:0]                 cnt_nxt_s;
    logic [8*N_DATA_PKTS-1:0]   data_sh_r;
    logic [6:0]                 ctl_r;
    logic [TO_W-1:0]            to_cnt_r;
    logic                       busy_r;
    logic                       rx_valid_r;
    logic [31:0]                rx_a_r;
    logic [31:0]                rx_b_r;
    logic [2:0]                 rx_op_r;
    logic                       rx_err_valid_r;
    rx_err_t                    rx_err_flags_r;

    logic                       start_s;
    logic                       pkt_bad_s;
    logic                       idle_wait_s;
    logic                       timeout_s;
    logic                       frame_act_nxt_s;
    logic                       busy_nxt_s;
    logic [3:0]                 crc_calc_s;
    logic                       crc_ok_s;
    logic                       op_ok_s;

    alu_rx_frame u_frame (
        .clk          (clk),
        .rst          (rst),
        .sin          (sin),
        .pkt_done     (pkt_done_s),
        .pkt_type     (pkt_type_s),
        .pkt_data     (pkt_data_s),
        .pkt_stop_err (pkt_stop_err_s),
        .frame_idle   (frame_idle_s),
        .frame_stop   (frame_stop_s)
    );

    assign start_s   = frame_idle_s & ~sin;
    assign pkt_bad_s = pkt_stop_err_s
                     | ((pkt_type_s == PKT_CTL)  & (cnt_r != CNT_FULL))
                     | ((pkt_type_s == PKT_DATA) & (cnt_r == CNT_FULL));

    // Only line-idle gaps inside a partial command advance the abandon timer.
    assign idle_wait_s = busy_r & frame_idle_s & sin & (state_r == S_COLLECT) & ~pkt_done_s;
    assign timeout_s   = (TIMEOUT_CYC != 0) && idle_wait_s && (to_cnt_r == TO_LAST);

    assign crc_calc_s = crc4_d68({data_sh_r, 1'b1, ctl_r[6:4]});
    assign crc_ok_s   = (crc_calc_s == ctl_r[3:0]);
    assign op_ok_s    = op_is_valid(ctl_r[6:4]);

    assign frame_act_nxt_s = start_s | (~frame_idle_s & ~frame_stop_s);
    assign busy_nxt_s      = frame_act_nxt_s | (cnt_nxt_s != 4'd0) | (state_nxt_s != S_COLLECT);

    assign rx_valid     = rx_valid_r;
    assign rx_a         = rx_a_r;
    assign rx_b         = rx_b_r;
    assign rx_op        = rx_op_r;
    assign rx_err_valid = rx_err_valid_r;
    assign rx_err_flags = rx_err_flags_r;
    assign rx_busy      = busy_r;

    // Command FSM next-state and packet counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_COLLECT: begin
                if (pkt_done_s) begin
                    if (pkt_bad_s) begin
                        state_nxt_s = S_REPORT;
                        cnt_nxt_s   = 4'd0;
                    end else if (pkt_type_s == PKT_DATA) begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end else begin
                        state_nxt_s = S_CHECK;
                        cnt_nxt_s   = 4'd0;
                    end
                end else if (timeout_s) begin
                    cnt_nxt_s = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            S_CHECK, S_REPORT: begin
                state_nxt_s = S_COLLECT;
                cnt_nxt_s   = 4'd0;
            end
            default: begin
                state_nxt_s = S_COLLECT;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Control state: FSM, packet count, busy flag and abandon timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_COLLECT;
            cnt_r    <= 4'd0;
            busy_r   <= 1'b0;
            to_cnt_r <= TO_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
            if (!idle_wait_s || timeout_s) begin
                to_cnt_r <= TO_ZERO;
            end else begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end
        end
    end

    // Operand staging: first DATA byte ends up in the top of B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sh_r <= '0;
            ctl_r     <= 7'd0;
        end else if (pkt_done_s && (state_r == S_COLLECT)) begin
            if (pkt_type_s == PKT_DATA) begin
                data_sh_r <= {data_sh_r[8*N_DATA_PKTS-9:0], pkt_data_s};
            end else begin
                ctl_r <= pkt_data_s[6:0];
            end
        end
    end

    // Result registers; ERR_CRC takes precedence over ERR_OP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_r     <= 1'b0;
            rx_a_r         <= 32'h0000_0000;
            rx_b_r         <= 32'h0000_0000;
            rx_op_r        <= 3'b000;
            rx_err_valid_r <= 1'b0;
            rx_err_flags_r <= ERR_NONE;
        end else begin
            rx_valid_r     <= 1'b0;
            rx_err_valid_r <= 1'b0;
            case (state_r)
                S_CHECK: begin
                    if (!crc_ok_s) begin
                        rx_err_valid_r <= 1'b1;
                        rx_err_flags_r <= ERR_CRC;
                    end else if (!op_ok_s) begin
                        rx_err_valid_r <= 1'b1;
                        rx_err_flags_r <= ERR_OP;
                    end else begin
                        rx_valid_r <= 1'b1;
                        rx_a_r     <= data_sh_r[31:0];
                        rx_b_r     <= data_sh_r[63:32];
                        rx_op_r    <= ctl_r[6:4];
                    end
                end
                S_REPORT: begin
                    rx_err_valid_r <= 1'b1;
                    rx_err_flags_r <= ERR_DATA;
                end
                default: begin
                    rx_err_flags_r <= rx_err_flags_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: drives packets on sin, checks result pulses,
// held values, timeout discard, mid-packet reset and back-to-back spacing.
module tb_alu_serial_rx;

    logic        clk;
    logic        rst;
    logic        sin;
    logic        rx_valid;
    logic [31:0] rx_a;
    logic [31:0] rx_b;
    logic [2:0]  rx_op;
    logic        rx_err_valid;
    logic [2:0]  rx_err_flags;
    logic        rx_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int last_cyc = 0;
    int prev_cyc = 0;
    int exp_nv = 0;
    int exp_ne = 0;

    logic [31:0] ma;
    logic [31:0] mb;
    logic [2:0]  mop;
    logic [2:0]  mflags;

    alu_serial_rx dut (
        .clk          (clk),
        .rst          (rst),
        .sin          (sin),
        .rx_valid     (rx_valid),
        .rx_a         (rx_a),
        .rx_b         (rx_b),
        .rx_op        (rx_op),
        .rx_err_valid (rx_err_valid),
        .rx_err_flags (rx_err_flags),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled on the inactive edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) begin
            n_valid  <= n_valid + 1;
            prev_cyc <= last_cyc;
            last_cyc <= cyc;
        end
        if (rx_err_valid) n_err <= n_err + 1;
        if (rx_valid && rx_err_valid) n_both <= n_both + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Polynomial long division of {d, 4'b0} by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [67:0] d);
        logic [71:0] r;
        r = {d, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] data, input logic stopb);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        send_bit(stopb);
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [3:0] crc_flip);
        logic [3:0] crc;
        crc = ref_crc({b, a, 1'b1, op}) ^ crc_flip;
        for (int i = 0; i < 4; i++) send_pkt(1'b0, b[31-8*i -: 8], 1'b1);
        for (int i = 0; i < 4; i++) send_pkt(1'b0, a[31-8*i -: 8], 1'b1);
        send_pkt(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    // Called right after the deciding stop bit is driven; pulse due 3 negedges later.
    task automatic expect_result(input string tag, input logic exp_valid);
        @(negedge clk);
        sin = 1'b1;
        @(negedge clk);
        check_eq({tag, "_early"}, {62'd0, rx_valid, rx_err_valid}, 64'd0);
        @(negedge clk);
        check_eq({tag, "_valid"}, {63'd0, rx_valid}, {63'd0, exp_valid});
        check_eq({tag, "_errv"}, {63'd0, rx_err_valid}, {63'd0, ~exp_valid});
        check_eq({tag, "_a"}, {32'd0, rx_a}, {32'd0, ma});
        check_eq({tag, "_b"}, {32'd0, rx_b}, {32'd0, mb});
        check_eq({tag, "_op"}, {61'd0, rx_op}, {61'd0, mop});
        check_eq({tag, "_flags"}, {61'd0, rx_err_flags}, {61'd0, mflags});
        check_eq({tag, "_busy"}, {63'd0, rx_busy}, 64'd0);
        @(negedge clk);
        check_eq({tag, "_width"}, {62'd0, rx_valid, rx_err_valid}, 64'd0);
        if (exp_valid) exp_nv++;
        else exp_ne++;
    endtask

    initial begin
        rst = 1'b1;
        sin = 1'b1;
        ma = 32'd0; mb = 32'd0; mop = 3'b000; mflags = 3'b000;
        repeat (3) @(negedge clk);
        check_eq("reset_ctl", {59'd0, rx_valid, rx_err_valid, rx_busy, rx_err_flags == 3'b000, rx_op == 3'b000},
                 64'd3);
        check_eq("reset_ab", {rx_a, rx_b}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: good ADD command
        send_cmd(32'h0000_0003, 32'h0000_0005, 3'b100, 4'h0);
        ma = 32'h0000_0003; mb = 32'h0000_0005; mop = 3'b100;
        expect_result("t1_add", 1'b1);

        // 2: corrupted CRC, operands held
        send_cmd(32'h0000_0003, 32'h0000_0005, 3'b100, 4'h1);
        mflags = 3'b010;
        expect_result("t2_crc", 1'b0);

        // 4: CTL after only 7 DATA packets, then recovery
        for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'(8'h10 + i), 1'b1);
        send_pkt(1'b1, 8'h4A, 1'b1);
        mflags = 3'b100;
        expect_result("t4_short", 1'b0);
        send_cmd(32'h0000_0003, 32'h0000_0005, 3'b100, 4'h0);
        expect_result("t4_recover", 1'b1);

        // 3: bad opcode with correct CRC
        send_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 4'h0);
        mflags = 3'b001;
        expect_result("t3_op", 1'b0);

        // stop bit sampled 0
        send_pkt(1'b0, 8'hA5, 1'b0);
        mflags = 3'b100;
        expect_result("stop_err", 1'b0);

        // 5: partial command abandoned after idle timeout
        for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'(8'h11 * (i + 1)), 1'b1);
        repeat (2) @(negedge clk);
        check_eq("t5_busy_partial", {63'd0, rx_busy}, 64'd1);
        repeat (80) @(negedge clk);
        check_eq("t5_busy_timeout", {63'd0, rx_busy}, 64'd0);
        send_cmd(32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 4'h0);
        ma = 32'h1234_5678; mb = 32'h9ABC_DEF0; mop = 3'b101;
        expect_result("t5_new", 1'b1);

        // 6: reset during the 5th packet
        for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'h5A, 1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        sin = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_outs", {rx_a, rx_b[28:0], rx_busy, rx_valid, rx_err_valid}, 64'd0);
        check_eq("t6_rst_flags", {58'd0, rx_op, rx_err_flags}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        ma = 32'd0; mb = 32'd0; mop = 3'b000; mflags = 3'b000;
        send_cmd(32'hDEAD_BEEF, 32'h00C0_FFEE, 3'b000, 4'h0);
        ma = 32'hDEAD_BEEF; mb = 32'h00C0_FFEE; mop = 3'b000;
        expect_result("t6_after_rst", 1'b1);

        // back-to-back commands, zero idle gap
        begin
            int nv0;
            nv0 = n_valid;
            send_cmd(32'h0000_00AA, 32'h0000_0055, 3'b001, 4'h0);
            send_cmd(32'h8000_0001, 32'h7FFF_FFFF, 3'b100, 4'h0);
            ma = 32'h8000_0001; mb = 32'h7FFF_FFFF; mop = 3'b100;
            expect_result("b2b_second", 1'b1);
            exp_nv++;
            repeat (3) @(negedge clk);
            check_eq("b2b_count", 64'(n_valid - nv0), 64'd2);
            check_eq("b2b_gap", 64'(last_cyc - prev_cyc), 64'd99);
        end

        repeat (5) @(negedge clk);
        check_eq("total_valid", 64'(n_valid), 64'(exp_nv));
        check_eq("total_err", 64'(n_err), 64'(exp_ne));
        check_eq("never_both", 64'(n_both), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
